aes_inv_key_sched: RTL and testbench

AES-128 inverse key schedule. It loads the round-10 key and walks the key expansion backwards, one round per clock, through the same RotWord/SubWord/Rcon recurrence used by forward expansion. It delivers round keys 10 down to 0 over a valid/ready stream, so the decryption datapath gets keys in use order without storing all eleven. It sits between the key-load logic and the inverse-cipher round engine.

---
 rtl/aes_inv_key_sched.sv | 130 +++++++++++++
 tb/tb_aes_inv_key_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: loads the round-10 key and streams round keys 10..0,
// stepping the expansion backwards by one round per accepted beat.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y_o = SBOX[a_i];
endmodule

module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_last,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  v0, v1, v2, v3;
    logic [3:0][7:0] rot, sub;
    logic [7:0]   rcon;

    assign {w0, w1, w2, w3} = key_q;
    assign v3  = w3 ^ w2;
    assign v2  = w2 ^ w1;
    assign v1  = w1 ^ w0;
    assign rot = {v3[23:0], v3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a_i(rot[g]), .y_o(sub[g]));
    end

    always_comb begin
        case (round_q)
            4'd10:   rcon = 8'h36;
            4'd9:    rcon = 8'h1b;
            4'd8:    rcon = 8'h80;
            4'd7:    rcon = 8'h40;
            4'd6:    rcon = 8'h20;
            4'd5:    rcon = 8'h10;
            4'd4:    rcon = 8'h08;
            4'd3:    rcon = 8'h04;
            4'd2:    rcon = 8'h02;
            4'd1:    rcon = 8'h01;
            default: rcon = 8'h00;
        endcase
    end

    assign v0 = w0 ^ sub ^ {rcon, 24'h0};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_last;
                    round_d = 4'd10;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    // Round 0 is terminal: the counter never wraps below zero.
                    if (round_q != 4'd0) begin
                        key_d   = {v0, v1, v2, v3};
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= 128'h0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign rk       = key_q;
    assign rk_round = round_q;
    assign rk_valid = (state_q == EMIT);
    assign busy     = (state_q == EMIT);
    assign done     = done_q;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Randomized bench for aes_inv_key_sched against a word-level key expansion model.

module tb_aes_inv_key_sched;
    logic         clk = 1'b0;
    logic         rst_n, start, rk_ready, rk_valid, busy, done;
    logic [127:0] key_last, rk;
    logic [3:0]   rk_round;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]   sb [256];
    logic [7:0]   rcon [1:10];
    logic [127:0] exp_rk [0:10];
    logic [127:0] obs_rk [0:10];

    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    always #5 clk = ~clk;

    aes_inv_key_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_last(key_last),
        .rk(rk), .rk_round(rk_round), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [31:0] t_word(input logic [31:0] x, input int r);
        logic [31:0] y;
        y = {x[23:0], x[31:24]};
        return {sb[y[31:24]], sb[y[23:16]], sb[y[15:8]], sb[y[7:0]]} ^ {rcon[r], 24'h0};
    endfunction

    // Undo the forward recurrence w[i] = w[i-4] ^ f(w[i-1]) from the top four words down.
    task automatic model(input logic [127:0] klast);
        logic [31:0] w [0:43];
        {w[40], w[41], w[42], w[43]} = klast;
        for (int i = 43; i >= 4; i--)
            w[i-4] = w[i] ^ ((i % 4 == 0) ? t_word(w[i-1], i / 4) : w[i-1]);
        for (int r = 0; r <= 10; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] fwd(input logic [127:0] k0);
        logic [31:0] w [0:43];
        {w[0], w[1], w[2], w[3]} = k0;
        for (int i = 4; i < 44; i++)
            w[i] = w[i-4] ^ ((i % 4 == 0) ? t_word(w[i-1], i / 4) : w[i-1]);
        return {w[40], w[41], w[42], w[43]};
    endfunction

    task automatic kick(input logic [127:0] k);
        start = 1'b1;
        key_last = k;
        @(negedge clk);
    endtask

    // Entered at the negedge of the first expected beat; leaves at a negedge.
    task automatic stream(input logic [127:0] k, input bit rnd, input int stall_r,
                          input bit inj, input int abort_r, input bit b2b,
                          input logic [127:0] k2, output int ncyc);
        int  r, stall, budget;
        bit  injd, acc;
        r = 10; stall = 0; budget = 0; injd = 0; ncyc = 0;
        model(k);
        while (r >= 0) begin
            start = 1'b0;
            chk("valid", rk_valid, 1);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("rk", rk, exp_rk[r]);
            chk("rk_round", rk_round, r[3:0]);
            obs_rk[r] = rk;
            if (r == abort_r) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_valid", rk_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_rk", rk, 0);
                chk("rst_round", rk_round, 0);
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_done", done, 0);
                end
                rst_n = 1'b1;
                return;
            end
            if (inj && r == 7 && !injd) begin
                start = 1'b1;
                key_last = '1;
                injd = 1;
            end
            if (r == stall_r && stall < 20) begin
                rk_ready = 1'b0;
                stall++;
            end else begin
                rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            acc = rk_ready;
            @(negedge clk);
            ncyc++;
            if (acc) r--;
            budget++;
            if (budget > 200) begin
                chk("timeout", 0, 1);
                return;
            end
        end
        chk("done", done, 1);
        chk("end_valid", rk_valid, 0);
        chk("end_busy", busy, 0);
        if (b2b) begin
            start = 1'b1;
            key_last = k2;
            @(negedge clk);
        end else begin
            start = 1'b0;
            @(negedge clk);
            chk("done_clear", done, 0);
        end
    endtask

    initial begin
        int nc;
        logic [127:0] k, k2;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 8'h0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sb[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
        rcon[1] = 8'h01;
        for (int i = 2; i <= 10; i++) rcon[i] = gmul(rcon[i-1], 8'h02);

        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_last = '0;
        #1;
        chk("reset_rk", rk, 0);
        chk("reset_round", rk_round, 0);
        chk("reset_valid", rk_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        kick(FIPS_K10);
        stream(FIPS_K10, 0, -1, 0, -1, 0, '0, nc);
        chk("fips_cycles", nc, 11);
        chk("fips_r10", obs_rk[10], FIPS_K10);
        chk("fips_r9", obs_rk[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("fips_r1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r0", obs_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        kick(FIPS_K10);
        stream(FIPS_K10, 1, 5, 1, -1, 0, '0, nc);
        chk("bp_r0", obs_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        kick(FIPS_K10);
        stream(FIPS_K10, 1, -1, 0, 4, 0, '0, nc);
        @(negedge clk);
        kick(128'h0);
        stream(128'h0, 0, -1, 0, -1, 0, '0, nc);
        chk("zero_fwd", fwd(obs_rk[0]), 0);

        k  = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        kick(k);
        stream(k, 0, -1, 0, -1, 1, k2, nc);
        stream(k2, 0, -1, 0, -1, 0, '0, nc);
        chk("b2b_cycles", nc, 11);

        for (int n = 0; n < 1000; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            kick(k);
            stream(k, 1, -1, 0, -1, 0, '0, nc);
            chk("rand_fwd", fwd(obs_rk[0]), k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
